// File: rtl/ifid_stage_if.sv
// ifid_stage_if: fetch-side inputs, EX hazard inputs and ID-side outputs.
// stall_cnt/flush_cnt exist only with IFID_PERF_CNT_EN defined.
interface ifid_stage_if;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic [31:0] f_inst;
  logic        redirect;
  logic        ext_stall;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic [4:0]  ex_rn;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  logic [31:0] d_inst;
  logic        d_valid;
  logic        stall;
  logic        bubble;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output f_pc, f_pc4, f_inst,
    output redirect, ext_stall,
    output ex_wreg, ex_m2reg, ex_rn,
`ifdef IFID_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  d_pc, d_pc4, d_inst,
    input  d_valid, stall, bubble
  );

  modport slave (
    input  f_pc, f_pc4, f_inst,
    input  redirect, ext_stall,
    input  ex_wreg, ex_m2reg, ex_rn,
`ifdef IFID_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output d_pc, d_pc4, d_inst,
    output d_valid, stall, bubble
  );
endinterface

// File: rtl/ifid_stage.sv
// ifid_stage: IF/ID pipeline register with load-use hazard detection.
// Define IFID_PERF_CNT_EN to add stall_cnt/flush_cnt counters.
module ifid_stage (
  input logic         clk,
  input logic         clrn,
  ifid_stage_if.slave bus
);
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        use_rt;
  logic        rs_hit;
  logic        rt_hit;
  logic        load_use;
  logic        stall;

  assign op = inst_q[31:26];
  assign rs = inst_q[25:21];
  assign rt = inst_q[20:16];

  always_comb begin
    use_rt = 1'b0;
    unique case (op)
      6'b000000,
      6'b101011,
      6'b000100,
      6'b000101: use_rt = 1'b1;
      default:   use_rt = 1'b0;
    endcase
  end

  assign rs_hit = (bus.ex_rn == rs);
  assign rt_hit = use_rt & (bus.ex_rn == rt);

  // a killed slot never raises a hazard
  assign load_use = valid_q & bus.ex_wreg
                  & bus.ex_m2reg
                  & (bus.ex_rn != 5'd0)
                  & (rs_hit | rt_hit);

  assign stall      = load_use | bus.ext_stall;
  assign bus.stall  = stall;
  assign bus.bubble = load_use & ~bus.ext_stall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (stall) begin
      pc_q    <= pc_q;
    end else if (bus.redirect) begin
      pc_q    <= bus.f_pc;
      pc4_q   <= bus.f_pc4;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= bus.f_pc;
      pc4_q   <= bus.f_pc4;
      inst_q  <= bus.f_inst;
      valid_q <= 1'b1;
    end
  end

  assign bus.d_pc    = pc_q;
  assign bus.d_pc4   = pc4_q;
  assign bus.d_inst  = inst_q;
  assign bus.d_valid = valid_q;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        flush;

  assign flush = bus.redirect & ~stall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: doc/ifid_stage.md
IFID_STAGE -- requirements
Module: ifid_stage

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- f_pc  in  32  PC of the fetched instruction (PC register output)
- f_pc4  in  32  f_pc+4 from the fetch adder
- f_inst  in  32  fetched instruction word
- redirect  in  1  branch/jump taken, resolved in ID this cycle
- ext_stall  in  1  external freeze request (multicycle unit busy)
- ex_wreg  in  1  EX-stage instruction writes a register
- ex_m2reg  in  1  EX-stage instruction is a load
- ex_rn  in  5  EX-stage destination register
- d_pc  out  32  latched PC for ID
- d_pc4  out  32  latched PC+4 for ID
- d_inst  out  32  latched instruction for ID
- d_valid  out  1  ID holds a real instruction
- stall  out  1  hold request to the PC register and this stage
- bubble  out  1  clear ID/EX control signals this cycle
REQ-002 The block SHALL use one clock (clk); reset clrn is asynchronous and active-low.

Function
REQ-003 Fields: rs=d_inst[25:21], rt=d_inst[20:16], op=d_inst[31:26].
REQ-004 use_rt SHALL be 1 when op is 000000, 101011, 000100 or 000101; otherwise 0.
REQ-005 load_use SHALL be combinational: d_valid & ex_wreg & ex_m2reg & (ex_rn!=0) & ((ex_rn==rs) | (use_rt & ex_rn==rt)).
REQ-006 stall SHALL equal load_use | ext_stall; bubble SHALL equal load_use & ~ext_stall.
REQ-007 Register update priority on each rising clk: clrn low > stall (hold all registers) > redirect (load f_pc/f_pc4, d_inst<=0, d_valid<=0) > normal (load f_pc, f_pc4, f_inst, d_valid<=1).
REQ-008 Stage latency SHALL be one cycle from f_* to d_*.
REQ-009 A load-use stall SHALL last exactly one cycle when EX receives the bubble (ex_wreg=0 next cycle); the block SHALL NOT add stall cycles of its own.
REQ-010 redirect together with stall SHALL be ignored that cycle; ID re-evaluates the held branch next cycle.
REQ-011 A killed slot (d_valid=0) SHALL never raise load_use.
REQ-012 ext_stall held for N cycles SHALL freeze d_* for exactly N cycles.

Reset
REQ-013 While clrn=0: d_pc=0, d_pc4=0, d_inst=0, d_valid=0; stall and bubble follow REQ-006 (therefore 0 unless ext_stall=1).
REQ-014 A reset asserted mid-stall SHALL take effect immediately and discard the held instruction; the first rising clk after clrn rises SHALL follow REQ-007 normally.

Configuration
REQ-015 With IFID_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
- stall_cnt increments on each clk with stall=1.
- flush_cnt increments on each clk with redirect=1 and stall=0.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
REQ-016 Without IFID_PERF_CNT_EN defined, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-017 Reset: clrn=0 with f_inst=0x8C010004 -> all d_* outputs=0, d_valid=0; stall=0 with ext_stall=0.
REQ-018 Normal flow: f_pc=0x00000010, f_inst=0x00221820 -> next cycle d_pc=0x10, d_pc4=0x14, d_inst=0x00221820, d_valid=1.
REQ-019 Load-use case:
- Stimulus: d_inst=0x00221820 (rs=1), ex_m2reg=1, ex_wreg=1, ex_rn=1.
- Required: stall=1 and bubble=1 for one cycle, d_* held; with ex_wreg=0 next cycle, stall=0.
- Required: ex_rn=0 in the same setup gives stall=0.
REQ-020 Redirect: redirect=1, stall=0, f_pc=0x20 -> next cycle d_inst=0, d_valid=0, d_pc=0x20; with redirect=1 and ext_stall=1 together, d_* unchanged.
REQ-021 Ext freeze with counter: ext_stall=1 for 3 cycles -> d_* frozen 3 cycles; with IFID_PERF_CNT_EN defined, stall_cnt=3; clrn pulsed low mid-freeze -> outputs 0 immediately and counters 0.
